lcd_frame_arbiter: RTL and testbench
====================================

# lcd_frame_arbiter

Frame-granular arbiter that shares the single pixel-FIFO write port in front of the LCD pixel writer between several pixel sources, such as the loading-screen generator and a framebuffer reader. It grants one source a whole frame at a time, round-robin. It pulses that source's new-frame strobe and forwards its pixels into the FIFO with backpressure. If the source drops out mid-frame, it pads the frame so the LCD always receives exactly H_ACTIVE×V_ACTIVE pixels.

## Interface
- NUM_SRC, 2, number of pixel sources (2..4)
- H_ACTIVE, 480, pixels per line
- V_ACTIVE, 272, lines per frame
- FILL_RGB, 24'h000000, pad colour used after a source abort
- clk_12  input  1  pixel-domain clock; every flop is on posedge
- rst  input  1  reset; asynchronous, active-low
- src_req  input  NUM_SRC  source i wants a frame; level signal
- src_grant  output  NUM_SRC  one-hot grant; held for the whole frame
- src_new_frame  output  NUM_SRC  one-cycle start strobe to the granted source
- src_valid  input  NUM_SRC  source i presents a pixel
- src_rgb  input  24*NUM_SRC  pixel bus; source i uses bits [24i+23:24i]
- src_ready  output  1  arbiter accepts the granted source's pixel this cycle
- fifo_wdata  output  24  FIFO write data
- fifo_wreq  output  1  FIFO write strobe
- fifo_full  input  1  FIFO write-side full
- busy  output  1  a frame is in progress (any state except IDLE)
- frame_done  output  1  one-cycle pulse after the last pixel is written
- aborted  output  1  sticky flag; set when any frame was padded, cleared when the next frame starts

## Operation
- States are IDLE, START, STREAM, PAD and DONE.
- IDLE: when src_req≠0, select the first requester at or after rr_ptr, cyclically. Register src_grant and go to START.
- START: assert src_new_frame[g] for exactly one cycle, clear x, y and aborted, then go to STREAM.
- STREAM:
  - src_ready = !fifo_full.
  - A transfer occurs when src_valid[g] && src_ready. On a transfer: fifo_wreq=1, fifo_wdata=src_rgb[g], and the x/y counters advance.
  - If src_req[g] deasserts before the last pixel, set aborted and go to PAD. A transfer in that same cycle is still taken.
- PAD: src_ready=0. Write FILL_RGB on every cycle in which !fifo_full, advancing x/y, until the frame is complete.
- Counter wrap: x wraps at H_ACTIVE-1 and then increments y. A write with x=H_ACTIVE-1 and y=V_ACTIVE-1 is the last pixel; from either STREAM or PAD, the next state is DONE.
- DONE: pulse frame_done, set rr_ptr=(g+1) mod NUM_SRC, clear src_grant, return to IDLE.
- Outside STREAM, src_valid is ignored. src_rgb of non-granted sources is ignored.
- Counter widths: x is $clog2(H_ACTIVE) bits, y is $clog2(V_ACTIVE) bits. No arithmetic overflow is possible, because wraps are compared explicitly.

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr 0, x=y=0. Reset asserted mid-frame aborts immediately with no padding. fifo_wreq must be 0 while rst is low.
- fifo_wreq, fifo_wdata and src_ready are combinational from state, fifo_full and src_valid. There is zero latency from source to FIFO, so the FIFO's full flag alone prevents overflow.
- Latency from src_req to src_new_frame: 2 cycles (IDLE→START). The first pixel can be accepted on the cycle after src_new_frame.
- Frame length: exactly H_ACTIVE*V_ACTIVE fifo_wreq pulses between START and DONE, regardless of stalls or aborts.
- Minimum gap between frames: DONE + IDLE + START = 3 cycles.
- If requests are simultaneous, rr_ptr decides. A request that arrives during a frame waits for the next IDLE.
- If fifo_full is high during PAD, the arbiter stalls without writing. Padding may take arbitrarily long.

## Structure
- Package lcd_pkg holds H_ACTIVE/V_ACTIVE defaults, the rgb_t typedef (24-bit) and the arb_state_t enum.
- Sub-module rr_pick (combinational): takes req and ptr and returns a one-hot grant. It is reused by future bus arbiters.

## Test plan
For speed, the bench uses H_ACTIVE=4 and V_ACTIVE=2.
- Single source 0 with continuous valid and fifo_full=0:
  - src_new_frame[0] at cycle 2.
  - 8 consecutive writes of its data.
  - frame_done 1 cycle after the 8th write.
  - aborted=0.
- Both sources request simultaneously and continuously: frames are granted in order 0,1,0,1, each with exactly 8 writes.
- fifo_full toggles every other cycle while valid is held: src_ready is low and no write occurs on full cycles, and all 8 pixels arrive in order.
- Source 1 drops src_req after 3 pixels: 5 writes of FILL_RGB follow, aborted=1, and the next frame clears aborted.
- rst pulsed low mid-STREAM: all outputs are 0 immediately, and a new request restarts with x=y=0.
- Source valid gaps: with src_valid low for 4 cycles mid-line, the counters hold and there are no spurious writes.

Source files
------------

// File: rtl/lcd_frame_arbiter_pkg.sv
// Shared types and defaults for the LCD frame arbiter.
package lcd_pkg;

  localparam int unsigned H_ACTIVE_DEF = 480;
  localparam int unsigned V_ACTIVE_DEF = 272;

  typedef logic [23:0] rgb_t;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StStream,
    StPad,
    StDone
  } arb_state_t;

endpackage

// File: rtl/lcd_frame_arbiter_if.sv
// Pixel-source and FIFO write-port bundle around the frame arbiter.
interface lcd_frame_arbiter_if #(
  parameter int unsigned NUM_SRC = 2
) ();
  import lcd_pkg::*;

  logic [NUM_SRC-1:0]    src_req;
  logic [NUM_SRC-1:0]    src_grant;
  logic [NUM_SRC-1:0]    src_new_frame;
  logic [NUM_SRC-1:0]    src_valid;
  logic [24*NUM_SRC-1:0] src_rgb;
  logic                  src_ready;
  rgb_t                  fifo_wdata;
  logic                  fifo_wreq;
  logic                  fifo_full;

  // Sources and FIFO (environment side).
  modport master (
    output src_req, src_valid, src_rgb, fifo_full,
    input  src_grant, src_new_frame, src_ready, fifo_wdata, fifo_wreq
  );

  // Arbiter side.
  modport slave (
    input  src_req, src_valid, src_rgb, fifo_full,
    output src_grant, src_new_frame, src_ready, fifo_wdata, fifo_wreq
  );

endinterface

// File: rtl/lcd_frame_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned PtrW = 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [PtrW-1:0] i_ptr,
  output logic [N-1:0]    o_grant
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned idx;
    logic        found;
    o_grant = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(i_ptr) + k) % N;
      if (!found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the LCD pixel FIFO.
// Pads aborted frames with FILL_RGB so every frame is H_ACTIVE*V_ACTIVE pixels.
module lcd_frame_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter rgb_t        FILL_RGB = 24'h000000
) (
  input  logic                clk_12,
  input  logic                rst,
  lcd_frame_arbiter_if.slave  bus,
  output logic                busy,
  output logic                frame_done,
  output logic                aborted
);

  localparam int unsigned PtrW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned XW    = $clog2(H_ACTIVE);
  localparam int unsigned YW    = $clog2(V_ACTIVE);
  localparam logic [XW-1:0] XLast = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YLast = YW'(V_ACTIVE - 1);

  arb_state_t          r_state;
  logic [NUM_SRC-1:0]  r_grant;
  logic [NUM_SRC-1:0]  r_new_frame;
  logic [PtrW-1:0]     r_ptr;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic                r_frame_done;
  logic                r_aborted;

  logic [NUM_SRC-1:0]  w_pick;
  logic                w_g_req;
  logic                w_g_valid;
  rgb_t                w_g_rgb;
  logic [PtrW-1:0]     w_g_idx;
  logic [PtrW-1:0]     w_ptr_nxt;
  logic                w_wreq;
  logic                w_x_last;
  logic                w_last;
  logic [XW-1:0]       w_x_nxt;
  logic [YW-1:0]       w_y_nxt;

  rr_pick #(
    .N    (NUM_SRC),
    .PtrW (PtrW)
  ) u_rr_pick (
    .i_req   (bus.src_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick)
  );

  // Select the granted source's pixel bus and index.
  always_comb begin
    w_g_rgb = '0;
    w_g_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_grant[i]) begin
        w_g_rgb = bus.src_rgb[24*i +: 24];
        w_g_idx = PtrW'(i);
      end
    end
  end

  assign w_g_req   = |(bus.src_req & r_grant);
  assign w_g_valid = |(bus.src_valid & r_grant);
  assign w_ptr_nxt = (w_g_idx == PtrW'(NUM_SRC - 1)) ? '0 : w_g_idx + 1'b1;
  assign w_x_last  = (r_x == XLast);
  assign w_last    = w_x_last && (r_y == YLast);

  // Raster position after the current write; cleared after the last pixel.
  always_comb begin
    w_x_nxt = r_x + 1'b1;
    w_y_nxt = r_y;
    if (w_x_last) begin
      w_x_nxt = '0;
      w_y_nxt = w_last ? '0 : r_y + 1'b1;
    end
  end

  // Zero-latency write path: only fifo_full throttles the source.
  always_comb begin
    w_wreq = 1'b0;
    if (!bus.fifo_full) begin
      w_wreq = ((r_state == StStream) && w_g_valid) || (r_state == StPad);
    end
  end

  assign bus.src_ready     = (r_state == StStream) && !bus.fifo_full;
  assign bus.fifo_wreq     = w_wreq;
  assign bus.fifo_wdata    = !w_wreq ? '0 : ((r_state == StPad) ? FILL_RGB : w_g_rgb);
  assign bus.src_grant     = r_grant;
  assign bus.src_new_frame = r_new_frame;
  assign busy              = (r_state != StIdle);
  assign frame_done        = r_frame_done;
  assign aborted           = r_aborted;

  // Frame FSM with registered grant, strobe and status outputs.
  always_ff @(posedge clk_12 or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_grant      <= '0;
      r_new_frame  <= '0;
      r_ptr        <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|bus.src_req) begin
            r_grant     <= w_pick;
            r_new_frame <= w_pick;
            r_state     <= StStart;
          end
        end
        StStart: begin
          r_new_frame <= '0;
          r_x         <= '0;
          r_y         <= '0;
          r_aborted   <= 1'b0;
          r_state     <= StStream;
        end
        StStream: begin
          if (w_wreq) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
          end
          if (w_wreq && w_last) begin
            r_frame_done <= 1'b1;
            r_state      <= StDone;
          end else if (!w_g_req) begin
            // A pixel taken in the drop cycle still counts; the rest is padded.
            r_aborted <= 1'b1;
            r_state   <= StPad;
          end
        end
        StPad: begin
          if (w_wreq) begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            if (w_last) begin
              r_frame_done <= 1'b1;
              r_state      <= StDone;
            end
          end
        end
        StDone: begin
          r_frame_done <= 1'b0;
          r_ptr        <= w_ptr_nxt;
          r_grant      <= '0;
          r_state      <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Scoreboard bench for lcd_frame_arbiter with a small 4x2 raster.
module tb_lcd_frame_arbiter;
  import lcd_pkg::*;

  localparam int unsigned NSRC = 2;
  localparam int unsigned HA   = 4;
  localparam int unsigned VA   = 2;
  localparam int          NPIX = HA * VA;
  localparam rgb_t        FILL = 24'h5A5A5A;
  localparam int          NO_ABORT = 99;

  logic clk_12 = 1'b0;
  logic rst    = 1'b0;
  logic busy, frame_done, aborted;

  lcd_frame_arbiter_if #(.NUM_SRC(NSRC)) bus_if ();

  lcd_frame_arbiter #(
    .NUM_SRC  (NSRC),
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .FILL_RGB (FILL)
  ) dut (
    .clk_12     (clk_12),
    .rst        (rst),
    .bus        (bus_if),
    .busy       (busy),
    .frame_done (frame_done),
    .aborted    (aborted)
  );

  always #5 clk_12 = ~clk_12;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard queues filled by the reference model.
  rgb_t            exp_px_q[$];
  logic [NSRC-1:0] exp_gnt_q[$];
  logic            exp_abt_q[$];

  // Reference model: round-robin pointer and per-source frame counts.
  int mptr;
  int mfrm[NSRC];
  int abort_tbl[NSRC][32];

  // Source model state.
  int              idx[NSRC];
  int              cur[NSRC];
  int              frm_cnt[NSRC];
  logic [NSRC-1:0] req_want;
  int              full_mode;
  int              gap_left;
  bit              valid_rand;

  // Monitor state.
  int              cyc, done_cnt, wr_in_frame;
  int              nf_cyc, first_wr_cyc, last_wr_cyc, done_cyc, req_rise_cyc;
  bit              gap_chk, gap_armed;
  logic [NSRC-1:0] prev_req;

  function automatic rgb_t px(input int s, input int f, input int j);
    return {4'hA, 4'(s), 8'(f), 8'(j)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  // Push the expected outcome of the next frame given the requesters at IDLE.
  task automatic sched(input logic [NSRC-1:0] reqs);
    int g;
    int ab;
    int n;
    logic [NSRC-1:0] oh;
    g = -1;
    for (int k = 0; k < NSRC; k++) begin
      int c;
      c = (mptr + k) % NSRC;
      if (g < 0 && reqs[c]) g = c;
    end
    if (g < 0) return;
    ab = abort_tbl[g][mfrm[g]];
    n  = (ab < NPIX) ? ab : NPIX;
    oh = '0;
    oh[g] = 1'b1;
    exp_gnt_q.push_back(oh);
    for (int j = 0; j < NPIX; j++) exp_px_q.push_back((j < n) ? px(g, mfrm[g], j) : FILL);
    exp_abt_q.push_back(ab < NPIX);
    mfrm[g]++;
    mptr = (g + 1) % NSRC;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_12);
      #1;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (done_cnt < target && c < budget) begin
      @(posedge clk_12);
      #1;
      c++;
    end
    chk(name, 32'(done_cnt >= target), 32'd1);
  endtask

  // Input driver: sources present pixels while granted, drop out per abort table.
  initial begin
    bus_if.src_req   = '0;
    bus_if.src_valid = '0;
    bus_if.src_rgb   = '0;
    bus_if.fifo_full = 1'b0;
    forever begin
      @(negedge clk_12);
      for (int i = 0; i < NSRC; i++) begin
        logic g, drop, v;
        g    = bus_if.src_grant[i];
        drop = g && (idx[i] >= abort_tbl[i][cur[i]]);
        bus_if.src_req[i] = req_want[i] && !drop;
        if (g) begin
          v = !drop;
          if (valid_rand && ($urandom_range(3) == 0)) v = 1'b0;
          if (idx[i] == 2 && gap_left > 0) begin
            v = 1'b0;
            gap_left--;
          end
          bus_if.src_rgb[24*i +: 24] = px(i, cur[i], idx[i]);
        end else begin
          v = 1'($urandom_range(1));
          bus_if.src_rgb[24*i +: 24] = 24'($urandom);
        end
        bus_if.src_valid[i] = v;
      end
      case (full_mode)
        1:       bus_if.fifo_full = ~bus_if.fifo_full;
        2:       bus_if.fifo_full = ($urandom_range(2) == 0);
        default: bus_if.fifo_full = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes, writes or finishes.
  initial begin
    logic [NSRC-1:0] eg;
    rgb_t            ep;
    logic            ea;
    prev_req = '0;
    forever begin
      @(negedge clk_12);
      #3;
      cyc++;
      if (rst) begin
        if (bus_if.src_req != '0 && prev_req == '0) req_rise_cyc = cyc;
        if (bus_if.fifo_full)
          chk("stall_on_full", 32'({bus_if.src_ready, bus_if.fifo_wreq}), 32'd0);
        if (bus_if.src_new_frame != '0) begin
          if (exp_gnt_q.size() == 0) fail_now("unexpected_frame", 32'(bus_if.src_new_frame));
          else begin
            eg = exp_gnt_q.pop_front();
            chk("grant_order", 32'(bus_if.src_new_frame), 32'(eg));
          end
          chk("grant_matches_strobe", 32'(bus_if.src_grant), 32'(bus_if.src_new_frame));
          chk("busy_in_frame", 32'(busy), 32'd1);
          if (gap_chk && gap_armed) chk("frame_gap", 32'(cyc - done_cyc), 32'd2);
          nf_cyc      = cyc;
          wr_in_frame = 0;
        end
        if (bus_if.fifo_wreq) begin
          wr_in_frame++;
          last_wr_cyc = cyc;
          if (wr_in_frame == 1) begin
            first_wr_cyc = cyc;
            chk("aborted_clear", 32'(aborted), 32'd0);
          end
          if (exp_px_q.size() == 0) fail_now("unexpected_write", 32'(bus_if.fifo_wdata));
          else begin
            ep = exp_px_q.pop_front();
            chk("pixel", 32'(bus_if.fifo_wdata), 32'(ep));
          end
        end
        if (frame_done) begin
          chk("frame_len", 32'(wr_in_frame), 32'(NPIX));
          chk("done_latency", 32'(cyc - last_wr_cyc), 32'd1);
          if (exp_abt_q.size() == 0) fail_now("unexpected_done", 32'(aborted));
          else begin
            ea = exp_abt_q.pop_front();
            chk("aborted_flag", 32'(aborted), 32'(ea));
          end
          done_cnt++;
          done_cyc  = cyc;
          gap_armed = 1'b1;
        end
        for (int i = 0; i < NSRC; i++) begin
          if (bus_if.src_new_frame[i]) begin
            idx[i] = 0;
            cur[i] = frm_cnt[i];
            frm_cnt[i]++;
          end else if (bus_if.src_valid[i] && bus_if.src_ready && bus_if.src_grant[i]) begin
            idx[i]++;
          end
        end
      end
      prev_req = bus_if.src_req;
    end
  end

  initial begin
    int base;
    int nf0;
    int c;
    for (int s = 0; s < NSRC; s++) begin
      mfrm[s] = 0; idx[s] = 0; cur[s] = 0; frm_cnt[s] = 0;
      for (int f = 0; f < 32; f++) abort_tbl[s][f] = NO_ABORT;
    end
    mptr = 0; req_want = '0; full_mode = 0; gap_left = 0; valid_rand = 1'b0;
    cyc = 0; done_cnt = 0; wr_in_frame = 0; gap_chk = 1'b0; gap_armed = 1'b0;
    nf_cyc = 0; first_wr_cyc = 0; last_wr_cyc = 0; done_cyc = 0; req_rise_cyc = 0;

    idle(3);
    chk("reset_wdata", 32'(bus_if.fifo_wdata), 32'd0);
    chk("reset_ctrl", 32'({bus_if.src_grant, bus_if.src_new_frame, bus_if.src_ready,
                           bus_if.fifo_wreq, busy, frame_done, aborted}), 32'd0);
    rst = 1'b1;
    idle(2);

    // Both sources requesting continuously: alternating grants, 3-cycle gap.
    gap_chk = 1'b1; gap_armed = 1'b0;
    base = done_cnt;
    req_want = 2'b11;
    repeat (4) sched(2'b11);
    wait_done(base + 4, 200, "rr_frames_done");
    req_want = '0; gap_chk = 1'b0;
    idle(5);

    // Single source 0, continuous valid: request-to-strobe and strobe-to-pixel latency.
    base = done_cnt;
    req_want = 2'b01;
    sched(2'b01);
    wait_done(base + 1, 100, "single_frame_done");
    req_want = '0;
    chk("req_to_strobe", 32'(nf_cyc - req_rise_cyc), 32'd1);
    chk("strobe_to_first_px", 32'(first_wr_cyc - nf_cyc), 32'd1);
    idle(4);

    // FIFO full toggling every cycle.
    base = done_cnt;
    full_mode = 1;
    req_want = 2'b01;
    sched(2'b01);
    wait_done(base + 1, 100, "full_toggle_done");
    req_want = '0; full_mode = 0;
    idle(4);

    // Source 1 drops out after 3 pixels, then a clean frame clears aborted.
    base = done_cnt;
    abort_tbl[1][mfrm[1]] = 3;
    req_want = 2'b10;
    sched(2'b10);
    sched(2'b10);
    wait_done(base + 2, 200, "abort_frames_done");
    req_want = '0;
    idle(4);

    // Valid gap of 4 cycles mid-line.
    base = done_cnt;
    gap_left = 4;
    req_want = 2'b01;
    sched(2'b01);
    wait_done(base + 1, 100, "gap_frame_done");
    req_want = '0;
    idle(4);

    // Reset mid-STREAM while source 1 owns the frame.
    nf0 = nf_cyc;
    req_want = 2'b10;
    sched(2'b10);
    c = 0;
    while (!(nf_cyc != nf0 && wr_in_frame >= 3) && c < 100) begin
      @(posedge clk_12);
      #1;
      c++;
    end
    chk("reset_point_reached", 32'(c < 100), 32'd1);
    rst = 1'b0;
    #1;
    chk("midreset_wdata", 32'(bus_if.fifo_wdata), 32'd0);
    chk("midreset_ctrl", 32'({bus_if.src_grant, bus_if.src_new_frame, bus_if.src_ready,
                              bus_if.fifo_wreq, busy, frame_done, aborted}), 32'd0);
    req_want = '0;
    exp_px_q.delete(); exp_gnt_q.delete(); exp_abt_q.delete();
    mptr = 0;
    idle(2);
    rst = 1'b1;
    idle(2);
    base = done_cnt;
    req_want = 2'b11;
    sched(2'b11);
    wait_done(base + 1, 100, "post_reset_frame_done");
    req_want = '0;
    idle(4);

    // Randomized: random full, random valid, random aborts, both requesting.
    base = done_cnt;
    full_mode = 2; valid_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int s = 0; s < NSRC; s++)
        abort_tbl[s][mfrm[s]] = ($urandom_range(1) == 1) ? NO_ABORT : int'($urandom_range(7, 1));
      sched(2'b11);
    end
    req_want = 2'b11;
    wait_done(base + 6, 1500, "random_frames_done");
    req_want = '0; full_mode = 0; valid_rand = 1'b0;
    idle(6);

    chk("pixels_left", 32'(exp_px_q.size()), 32'd0);
    chk("frames_left", 32'(exp_gnt_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
